// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the scoreboarded register file.
package regfile_pkg;
   typedef enum logic {INIT, RUN} state_t;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy flags for long-latency writes.
// Ports: set_en_i/set_a_i mark a register busy, clr_en_i/clr_a_i release it
// (set wins on collision), a1_i/a2_i -> busy1_o/busy2_o lookups.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int AW     = $clog2(NREG),
   parameter int BYPASS = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en_i,
   input  logic [AW-1:0] set_a_i,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_a_i,
   input  logic [AW-1:0] a1_i,
   input  logic [AW-1:0] a2_i,
   output logic          busy1_o,
   output logic          busy2_o
);
   logic [NREG-1:0] busy_q, busy_d;
   logic            fwd1, fwd2;
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_a_i] = 1'b0;
      if (set_en_i) busy_d[set_a_i] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      busy_q <= rst_n ? busy_d : '0;
   end
   // A completing late write hides the flag in its own cycle unless re-issued.
   assign fwd1 = (BYPASS != 0) && clr_en_i && clr_a_i == a1_i && !(set_en_i && set_a_i == a1_i);
   assign fwd2 = (BYPASS != 0) && clr_en_i && clr_a_i == a2_i && !(set_en_i && set_a_i == a2_i);
   assign busy1_o = busy_q[a1_i] && !fwd1;
   assign busy2_o = busy_q[a2_i] && !fwd2;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with zeroing init sweep, write bypass and busy scoreboard.
// Ports: clk, rst_n (sync, active-low), ready; A1/A2 -> RD1/RD2, Busy1/Busy2;
// WEn3/A3/WD3 primary write; WEn4/A4/WD4 late write (clears busy); IssEn/IssRd set busy.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int AW     = $clog2(NREG),
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            ready,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic            Busy1,
   output logic            Busy2,
   input  logic            WEn3,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            WEn4,
   input  logic [AW-1:0]   A4,
   input  logic [XLEN-1:0] WD4,
   input  logic            IssEn,
   input  logic [AW-1:0]   IssRd
);
   localparam logic [AW-1:0] LAST = AW'(NREG - 1);
   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [XLEN-1:0] regs_q [NREG];
   logic            run, wr3, wr4, sb1, sb2;
   assign run = state_q == RUN;
   assign wr3 = run && WEn3 && A3 != '0;
   assign wr4 = run && WEn4 && A4 != '0;
   assign ready = run;
   always_comb begin
      state_d = (state_q == INIT && idx_q == LAST) ? RUN : state_q;
      idx_d   = (state_q == INIT) ? idx_q + AW'(1) : idx_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= INIT;
         idx_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end
   // No reset term on the array: contents are cleared only by the sweep.
   // Port 3 is written last so it wins an address collision with port 4.
   always_ff @(posedge clk) begin
      if (rst_n && !run) regs_q[idx_q] <= '0;
      if (rst_n && wr4) regs_q[A4] <= WD4;
      if (rst_n && wr3) regs_q[A3] <= WD3;
   end
   assign RD1 = (!run || A1 == '0) ? '0 :
                (BYPASS != 0 && wr3 && A3 == A1) ? WD3 :
                (BYPASS != 0 && wr4 && A4 == A1) ? WD4 : regs_q[A1];
   assign RD2 = (!run || A2 == '0) ? '0 :
                (BYPASS != 0 && wr3 && A3 == A2) ? WD3 :
                (BYPASS != 0 && wr4 && A4 == A2) ? WD4 : regs_q[A2];
   regfile_scoreboard #(.NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en_i (run && IssEn),
      .set_a_i  (IssRd),
      .clr_en_i (run && WEn4),
      .clr_a_i  (A4),
      .a1_i     (A1),
      .a2_i     (A2),
      .busy1_o  (sb1),
      .busy2_o  (sb2)
   );
   assign Busy1 = run && sb1;
   assign Busy2 = run && sb2;
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, minimum 4.
REQ-003 SHALL have parameter AW, default $clog2(NREG), register address width.
REQ-004 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ready  out  1  high once the init sweep is complete.
REQ-008 SHALL have ports A1, A2  in  AW  read addresses.
REQ-009 SHALL have ports RD1, RD2  out  XLEN  read data, combinational.
REQ-010 SHALL have ports Busy1, Busy2  out  1  pending-write flag of A1 / A2, combinational.
REQ-011 SHALL have ports WEn3 in 1, A3 in AW, WD3 in XLEN  primary (single-cycle pipeline) write port.
REQ-012 SHALL have ports WEn4 in 1, A4 in AW, WD4 in XLEN  late write port (multi-cycle M-unit result); it clears the busy flag.
REQ-013 SHALL have ports IssEn in 1, IssRd in AW  issue of a long-latency op that will write IssRd; it sets the busy flag.

Function
REQ-014 SHALL implement two states: INIT (sweeping) and RUN (normal).
REQ-015 In INIT, SHALL write zero to regs[idx] on each edge with rst_n=1, idx running 1..NREG-1, then enter RUN with ready=1; ready rises exactly NREG-1 edges after rst_n goes high.
REQ-016 In INIT, SHALL ignore WEn3, WEn4 and IssEn, and SHALL drive RD1/RD2/Busy1/Busy2 to 0.
REQ-017 Register 0 SHALL read 0 always, SHALL never be written and SHALL never be busy; writes or issues addressed to 0 are dropped.
REQ-018 In RUN, port 3 SHALL write regs[A3]<=WD3 when WEn3=1; port 4 SHALL write regs[A4]<=WD4 when WEn4=1.
REQ-019 When WEn3 and WEn4 target the same nonzero address in one cycle, port 3 SHALL win (younger instruction); port 4 still clears the busy flag.
REQ-020 When BYPASS=1, RDn SHALL return WD3 if WEn3 and A3==An!=0, else WD4 if WEn4 and A4==An!=0, else regs[An]; when BYPASS=0, RDn SHALL return regs[An] (new value visible the next cycle).
REQ-021 Scoreboard: IssEn=1 SHALL set busy[IssRd] at the edge; WEn4=1 SHALL clear busy[A4] at the edge; a port 3 write SHALL NOT affect busy.
REQ-022 Simultaneous IssEn and WEn4 to the same register SHALL leave busy set (set wins).
REQ-023 Busyn SHALL equal busy[An] from the current flop state; when BYPASS=1, Busyn SHALL read 0 in a cycle where WEn4 clears An and IssEn does not set An.
REQ-024 WEn4 to a non-busy register SHALL still write data; the clear is a no-op.

Reset
REQ-025 rst_n=0 at an edge SHALL force state=INIT, idx=1, ready=0, and all busy flags to 0.
REQ-026 Reset asserted mid-sweep or in RUN SHALL restart the sweep from idx=1; writes presented in the reset cycle are discarded.
REQ-027 Register contents SHALL be cleared only by the sweep, never by a reset term on the array, so the array maps to RAM/LUT storage.

Structure
REQ-028 Shared package regfile_pkg SHALL hold the state enum (INIT, RUN) and default XLEN/NREG constants.
REQ-029 The busy-flag array and its set/clear logic SHALL live in one sub-module, regfile_scoreboard (NREG flags, set port, clear port, two lookup ports).
REQ-030 The top level SHALL hold the storage array, the sweep FSM with its idx counter, and the bypass muxes.

Verification
REQ-031 Reset then release, NREG=32 -> ready=0 for 31 edges, ready=1 on the 31st; every register reads 0 afterwards.
REQ-032 RUN: WEn3=1, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle -> RD1=0xDEADBEEF combinationally (BYPASS=1); 0 before the edge with BYPASS=0.
REQ-033 WEn3 and WEn4 both to A=7 (WD3=0x11, WD4=0x22) -> regs[7]=0x11 next cycle; busy[7] cleared.
REQ-034 IssEn with IssRd=9 -> Busy1=1 for A1=9 until WEn4 with A4=9 and WD4=0x1234 -> Busy1=0 and RD1=0x1234 in that cycle; IssEn and WEn4 both to 9 in one cycle -> busy stays 1.
REQ-035 Writes, issues and reads addressed to 0 (WD3=0xFFFFFFFF) -> RD1=0 and Busy1=0 always.
REQ-036 rst_n low for one cycle in RUN with busy[3]=1 and regs[3]=0x55 -> busy cleared, ready=0, regs[3]=0 after 31 edges.
